// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider for the EX stage.
// It implements RV32M DIV/DIVU/REM/REMU, including the divide-by-zero and
// signed-overflow results. A normal divide shows ready_o 33 cycles after the
// start cycle. The special cases show ready_o one cycle after the start cycle.
// Optional shortcut: define DIV_EARLY_OUT_EN to skip iterating when
// |dividend| < |divisor|. The result is then quotient 0, remainder = dividend.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start_i        divide request for the instruction in EX
//   signed_i       1 = DIV/REM, 0 = DIVU/REMU
//   annul_i        flush; aborts an operation in progress
//   dividend_i     dividend (register 1 data)
//   divisor_i      divisor (register 2 data)
//   quot_o, rem_o  registered quotient / remainder, held until the next start
//   ready_o        one-cycle result-valid pulse (registered)
//   stallreq_o     combinational stall request to the stall controller
module ex_div #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ready_o,
    output logic             stallreq_o
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs, dvs_nxt;     // divisor magnitude
    logic [WIDTH-1:0] prem, prem_nxt;   // partial remainder
    logic             q_neg, q_neg_nxt;
    logic             r_neg, r_neg_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt;
    logic             ready_nxt;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] q_shift, r_step;

    // Operand magnitudes and signs; raw operands when unsigned
    always_comb begin
        a_neg = signed_i & dividend_i[WIDTH-1];
        b_neg = signed_i & divisor_i[WIDTH-1];
        mag_a = a_neg ? -dividend_i : dividend_i;
        mag_b = b_neg ? -divisor_i  : divisor_i;
    end

    // One restoring step. The WIDTH+1-bit trial keeps the shifted-out MSB,
    // so unsigned divisors with the top bit set are handled correctly.
    always_comb begin
        rem_sh  = {prem, dvd[WIDTH-1]};
        trial   = rem_sh - {1'b0, dvs};
        q_shift = {dvd[WIDTH-2:0], ~trial[WIDTH]};
        r_step  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Next-state and datapath control
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dvd_nxt    = dvd;
        dvs_nxt    = dvs;
        prem_nxt   = prem;
        q_neg_nxt  = q_neg;
        r_neg_nxt  = r_neg;
        quot_nxt   = quot_o;
        rem_nxt    = rem_o;
        ready_nxt  = 1'b0;
        stallreq_o = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    if (divisor_i == '0) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                        quot_nxt  = '1;
                        rem_nxt   = dividend_i;
                    end else if (signed_i && dividend_i == MIN_NEG && divisor_i == '1) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                        quot_nxt  = MIN_NEG;
                        rem_nxt   = '0;
`ifdef DIV_EARLY_OUT_EN
                    end else if (mag_a < mag_b) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                        quot_nxt  = '0;
                        rem_nxt   = dividend_i;
`endif
                    end else begin
                        state_nxt = BUSY;
                        dvd_nxt   = mag_a;
                        dvs_nxt   = mag_b;
                        q_neg_nxt = a_neg ^ b_neg;
                        r_neg_nxt = a_neg;
                        prem_nxt  = '0;
                        cnt_nxt   = '0;
                    end
                end
            end
            BUSY: begin
                stallreq_o = 1'b1;
                if (annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    dvd_nxt  = q_shift;
                    prem_nxt = r_step;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state_nxt = DONE;
                        ready_nxt = 1'b1;
                        quot_nxt  = q_neg ? -q_shift : q_shift;
                        rem_nxt   = r_neg ? -r_step  : r_step;
                    end
                end
            end
            DONE: begin
                // Result pulses regardless of annul_i; start_i is not sampled here
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            prem    <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            quot_o  <= '0;
            rem_o   <= '0;
            ready_o <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            dvd     <= dvd_nxt;
            dvs     <= dvs_nxt;
            prem    <= prem_nxt;
            q_neg   <= q_neg_nxt;
            r_neg   <= r_neg_nxt;
            quot_o  <= quot_nxt;
            rem_o   <= rem_nxt;
            ready_o <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: scoreboard bench for ex_div. It runs directed corner cases and
// then randomized divides. Each result is checked against an arithmetic
// reference model that also gives the expected ready cycle.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [31:0] quot_o;
    logic [31:0] rem_o;
    logic        ready_o;
    logic        stallreq_o;

    ex_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .annul_i    (annul_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .quot_o     (quot_o),
        .rem_o      (rem_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          start_cyc = 0;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain RV32M arithmetic plus expected latency
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb_l, ma, mb;
        if (s) begin
            sa   = longint'($signed(a));
            sb_l = longint'($signed(b));
        end else begin
            sa   = longint'({32'd0, a});
            sb_l = longint'({32'd0, b});
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb_l < 0) ? -sb_l : sb_l;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; lat = 1;
        end else begin
            q = 32'(sa / sb_l);
            r = 32'(sa % sb_l);
            lat = 33;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) lat = 1;
`else
            if (ma < mb) lat = 33;
`endif
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse
    always @(negedge clk) begin
        if (rst_n && ready_o) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready: ready_o=1 expected 0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quot", quot_o, e.q);
                chk("rem", rem_o, e.r);
                chk("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
            if (prev_ready) chk("ready_pulse_width", 32'(prev_ready), 32'd0);
        end
        prev_ready = ready_o;
    end

    // Issue one start in the current cycle, then leave the bench in cycle 1.
    // With push=1 the expected result is queued; lat returns the model latency.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit s,
                         input bit push, output int lat);
        logic [31:0] q, r;
        exp_t e;
        model(a, b, s, q, r, lat);
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        start_cyc = cyc;
        if (push) begin
            e.q = q; e.r = r; e.cyc = start_cyc + lat;
            sb.push_back(e);
            last_q = q; last_r = r;
        end
        @(negedge clk);
        chk("stall_cycle0", 32'(stallreq_o), 32'(!annul_i));
        @(posedge clk); #1;
        start_i = 1'b0; dividend_i = $urandom; divisor_i = $urandom; signed_i = 1'($urandom);
    endtask

    // Check stallreq_o is high for cycles below lat, then drain the scoreboard
    task automatic finish_op(input int lat);
        bit bad = 1'b0;
        logic got_stall = 1'b0;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (stallreq_o !== ((cyc - start_cyc) < lat)) begin
                bad = 1'b1;
                got_stall = stallreq_o;
            end
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL stall_window: stallreq_o=%b wrong inside %0d-cycle op", got_stall, lat);
        end
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL ready_timeout: %0d results pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s);
        int lat;
        issue(a, b, s, 1'b1, lat);
        finish_op(lat);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_quot", quot_o, 32'd0);
        chk("reset_rem", rem_o, 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_stall", 32'(stallreq_o), 32'd0);

        // Directed cases
        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFF9, 32'd2, 1'b1);
        run(32'd5, 32'd0, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run(32'd3, 32'd10, 1'b0);
        run(32'hFFFF_FFF9, 32'd10, 1'b1);

        // Annul while busy: no ready, outputs held, stall drops next cycle
        issue(32'd50, 32'd3, 1'b0, 1'b0, lat);
        while (cyc < start_cyc + 10) begin @(posedge clk); #1; end
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        chk("annul_stall", 32'(stallreq_o), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("annul_quot_held", quot_o, last_q);
        chk("annul_rem_held", rem_o, last_r);
        run(32'd9, 32'd4, 1'b0);

        // Annul together with start: not accepted
        annul_i = 1'b1;
        issue(32'd40, 32'd6, 1'b0, 1'b0, lat);
        annul_i = 1'b0;
        repeat (40) @(posedge clk);

        // Annul during DONE is ignored
        issue(32'd5, 32'd0, 1'b0, 1'b1, lat);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        repeat (3) @(posedge clk);
        chk("done_annul_drained", 32'(sb.size()), 32'd0);
        sb.delete();

        // Reset mid-operation
        issue(32'd1000, 32'd7, 1'b0, 1'b0, lat);
        while (cyc < start_cyc + 5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_quot", quot_o, 32'd0);
        chk("midrst_rem", rem_o, 32'd0);
        chk("midrst_ready", 32'(ready_o), 32'd0);
        chk("midrst_stall", 32'(stallreq_o), 32'd0);
        repeat (40) @(posedge clk);

        // Randomized operands with corner-case biasing
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            bit s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 15));
                1: a = 32'($urandom_range(0, 100));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: b = 32'd0;
                default: ;
            endcase
            run(a, b, s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
